// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM with one-cycle read latency.
// Contention alternates between masters; out-of-range accesses are absorbed and flagged.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 10240
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W-1:0]   a_writedata,
    output logic                a_waitrequest,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W-1:0]   b_writedata,
    output logic                b_waitrequest,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                range_err
);

    typedef enum logic {MASTER_A = 1'b0, MASTER_B = 1'b1} master_t;

    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    master_t             r_lastGrant;
    master_t             r_pendOwner;
    logic                r_pendValid;
    logic                r_pendOor;
    logic                r_rangeErr;

    logic                w_aReq;
    logic                w_bReq;
    logic                w_grantA;
    logic                w_grantB;
    logic                w_grant;
    logic                w_winWrite;
    logic                w_inRange;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_readData;

    assign w_aReq = a_read | a_write;
    assign w_bReq = b_read | b_write;

    // Under contention the master that did not win last time gets the slot.
    assign w_grantA = !reset && w_aReq && (!w_bReq || (r_lastGrant == MASTER_B));
    assign w_grantB = !reset && w_bReq && (!w_aReq || (r_lastGrant == MASTER_A));
    assign w_grant  = w_grantA | w_grantB;

    assign w_addr     = w_grantB ? b_address : a_address;
    assign w_winWrite = w_grantB ? b_write : a_write;
    assign w_inRange  = ({1'b0, w_addr} < DEPTH_LIM);

    assign a_waitrequest = reset || (w_aReq && !w_grantA);
    assign b_waitrequest = reset || (w_bReq && !w_grantB);

    assign mem_address    = w_addr;
    assign mem_byteenable = w_grantB ? b_byteenable : a_byteenable;
    assign mem_writedata  = w_grantB ? b_writedata : a_writedata;
    assign mem_chipselect = w_grant && w_inRange;
    assign mem_write      = w_grant && w_inRange && w_winWrite;
    assign mem_clken      = !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastGrant <= MASTER_B;
            r_pendValid <= 1'b0;
            r_pendOwner <= MASTER_A;
            r_pendOor   <= 1'b0;
            r_rangeErr  <= 1'b0;
        end else begin
            if (w_grantA) begin
                r_lastGrant <= MASTER_A;
            end else if (w_grantB) begin
                r_lastGrant <= MASTER_B;
            end
            r_pendValid <= w_grant && !w_winWrite;
            r_pendOwner <= w_grantB ? MASTER_B : MASTER_A;
            r_pendOor   <= !w_inRange;
            r_rangeErr  <= w_grant && !w_inRange;
        end
    end

    // Reset gates the pending record so a read caught by reset never returns.
    assign w_readData      = r_pendOor ? '0 : mem_readdata;
    assign a_readdatavalid = !reset && r_pendValid && (r_pendOwner == MASTER_A);
    assign b_readdatavalid = !reset && r_pendValid && (r_pendOwner == MASTER_B);
    assign a_readdata      = a_readdatavalid ? w_readData : '0;
    assign b_readdata      = b_readdatavalid ? w_readData : '0;
    assign range_err       = !reset && r_rangeErr;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter: a behavioural RAM sits behind the arbiter and
// every read return is matched against an expectation queued when the read was issued.
module tb_onchip_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 10240;

    typedef struct packed {
        logic [31:0] cyc;
        logic        owner;
        logic [31:0] data;
        logic        oor;
    } expect_t;

    logic                clk;
    logic                reset;
    logic [ADDR_W-1:0]   a_address;
    logic [DATA_W/8-1:0] a_byteenable;
    logic                a_read;
    logic                a_write;
    logic [DATA_W-1:0]   a_writedata;
    logic                a_waitrequest;
    logic [DATA_W-1:0]   a_readdata;
    logic                a_readdatavalid;
    logic [ADDR_W-1:0]   b_address;
    logic [DATA_W/8-1:0] b_byteenable;
    logic                b_read;
    logic                b_write;
    logic [DATA_W-1:0]   b_writedata;
    logic                b_waitrequest;
    logic [DATA_W-1:0]   b_readdata;
    logic                b_readdatavalid;
    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;
    logic                range_err;

    int          checkCount;
    int          errorCount;
    int          cycleCnt;
    expect_t     sbQueue[$];
    logic [31:0] ramArr [0:DEPTH-1];

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read),
        .a_write(a_write), .a_writedata(a_writedata), .a_waitrequest(a_waitrequest),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read),
        .b_write(b_write), .b_writedata(b_writedata), .b_waitrequest(b_waitrequest),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .range_err(range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Behavioural single-port RAM, one-cycle registered read, byte-lane writes.
    initial begin
        for (int i = 0; i < DEPTH; i++) ramArr[i] = '0;
        mem_readdata = '0;
    end
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int i = 0; i < DATA_W/8; i++) begin
                    if (mem_byteenable[i]) ramArr[int'(mem_address)][i*8 +: 8] <= mem_writedata[i*8 +: 8];
                end
            end
            mem_readdata <= ramArr[int'(mem_address)];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, actual, expected, cycleCnt);
        end
    endtask

    task automatic applyStimulus(input logic master, input logic rd, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                                 input logic [31:0] data);
        if (master == 1'b0) begin
            a_read = rd; a_write = wr; a_address = addr; a_byteenable = be; a_writedata = data;
        end else begin
            b_read = rd; b_write = wr; b_address = addr; b_byteenable = be; b_writedata = data;
        end
    endtask

    task automatic idleMasters();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpect(input logic owner, input logic [31:0] data, input logic oor);
        expect_t e;
        e.cyc   = cycleCnt + 1;
        e.owner = owner;
        e.data  = data;
        e.oor   = oor;
        sbQueue.push_back(e);
    endtask

    // Every cycle: either a queued read return is due, or both return channels must be quiet.
    always @(negedge clk) begin
        expect_t e;
        if (sbQueue.size() > 0 && sbQueue[0].cyc == cycleCnt) begin
            e = sbQueue.pop_front();
            checkOutput("aValid", {31'd0, a_readdatavalid}, {31'd0, !e.owner});
            checkOutput("bValid", {31'd0, b_readdatavalid}, {31'd0, e.owner});
            checkOutput("aData", a_readdata, e.owner ? 32'd0 : e.data);
            checkOutput("bData", b_readdata, e.owner ? e.data : 32'd0);
            checkOutput("rangeErr", {31'd0, range_err}, {31'd0, e.oor});
        end else begin
            checkOutput("aValidIdle", {31'd0, a_readdatavalid}, 32'd0);
            checkOutput("bValidIdle", {31'd0, b_readdatavalid}, 32'd0);
            checkOutput("rangeErrIdle", {31'd0, range_err}, 32'd0);
        end
    end

    initial begin
        logic prevAWait;
        logic prevBWait;
        logic expA;
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        idleMasters();
        applyStimulus(1'b0, 1'b1, 1'b0, 14'd5, 4'hF, '0);

        // Reset holds everything quiet even with a request pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("aWaitRst", {31'd0, a_waitrequest}, 32'd1);
        checkOutput("bWaitRst", {31'd0, b_waitrequest}, 32'd1);
        checkOutput("csRst", {31'd0, mem_chipselect}, 32'd0);
        checkOutput("memWriteRst", {31'd0, mem_write}, 32'd0);
        checkOutput("clkenRst", {31'd0, mem_clken}, 32'd0);
        nextCycle();
        reset = 1'b0;
        idleMasters();

        // First contention after reset goes to A, then B.
        applyStimulus(1'b0, 1'b1, 1'b0, 14'd1, 4'hF, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 14'd2, 4'hF, '0);
        @(negedge clk);
        checkOutput("clken", {31'd0, mem_clken}, 32'd1);
        checkOutput("contAWait", {31'd0, a_waitrequest}, 32'd0);
        checkOutput("contBWait", {31'd0, b_waitrequest}, 32'd1);
        checkOutput("contAddrA", {18'd0, mem_address}, 32'd1);
        checkOutput("contCs", {31'd0, mem_chipselect}, 32'd1);
        pushExpect(1'b0, 32'd0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("contBWait2", {31'd0, b_waitrequest}, 32'd0);
        checkOutput("contAddrB", {18'd0, mem_address}, 32'd2);
        pushExpect(1'b1, 32'd0, 1'b0);
        nextCycle();
        idleMasters();
        @(negedge clk);
        checkOutput("idleCs", {31'd0, mem_chipselect}, 32'd0);
        nextCycle();

        // Full-word write and readback.
        applyStimulus(1'b0, 1'b0, 1'b1, 14'd5, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("wrMemWrite", {31'd0, mem_write}, 32'd1);
        checkOutput("wrCs", {31'd0, mem_chipselect}, 32'd1);
        checkOutput("wrData", mem_writedata, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 14'd5, 4'hF, '0);
        @(negedge clk);
        checkOutput("rdMemWrite", {31'd0, mem_write}, 32'd0);
        pushExpect(1'b0, 32'hDEADBEEF, 1'b0);
        nextCycle();

        // Partial write into a zeroed word only touches the enabled lanes.
        applyStimulus(1'b0, 1'b0, 1'b1, 14'd7, 4'h3, 32'h11223344);
        @(negedge clk);
        checkOutput("wrBe", {28'd0, mem_byteenable}, 32'h3);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 14'd7, 4'hF, '0);
        @(negedge clk);
        pushExpect(1'b0, 32'h00003344, 1'b0);
        nextCycle();

        // Read and write together behave as a write: no return follows.
        applyStimulus(1'b0, 1'b1, 1'b1, 14'd9, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("rwMemWrite", {31'd0, mem_write}, 32'd1);
        nextCycle();
        idleMasters();
        applyStimulus(1'b1, 1'b1, 1'b0, 14'd9, 4'hF, '0);
        @(negedge clk);
        checkOutput("rwBAddr", {18'd0, mem_address}, 32'd9);
        pushExpect(1'b1, 32'hCAFEF00D, 1'b0);
        nextCycle();

        // Continuous contention: B won last, so grants run A,B,A,B,...
        applyStimulus(1'b0, 1'b1, 1'b0, 14'd5, 4'hF, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 14'd9, 4'hF, '0);
        prevAWait = 1'b0;
        prevBWait = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expA = (i % 2 == 0);
            @(negedge clk);
            checkOutput("altAWait", {31'd0, a_waitrequest}, {31'd0, !expA});
            checkOutput("altBWait", {31'd0, b_waitrequest}, {31'd0, expA});
            checkOutput("altAddr", {18'd0, mem_address}, expA ? 32'd5 : 32'd9);
            checkOutput("altARun", {31'd0, prevAWait & a_waitrequest}, 32'd0);
            checkOutput("altBRun", {31'd0, prevBWait & b_waitrequest}, 32'd0);
            prevAWait = a_waitrequest;
            prevBWait = b_waitrequest;
            pushExpect(!expA, expA ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0);
            nextCycle();
        end
        idleMasters();
        nextCycle();

        // Out-of-range read: RAM untouched, zero data returned with an error pulse.
        applyStimulus(1'b1, 1'b1, 1'b0, 14'd10240, 4'hF, '0);
        @(negedge clk);
        checkOutput("oorCs", {31'd0, mem_chipselect}, 32'd0);
        checkOutput("oorBWait", {31'd0, b_waitrequest}, 32'd0);
        pushExpect(1'b1, 32'd0, 1'b1);
        nextCycle();
        idleMasters();
        nextCycle();

        // A read whose return cycle is hit by reset never returns.
        applyStimulus(1'b0, 1'b1, 1'b0, 14'd5, 4'hF, '0);
        @(negedge clk);
        checkOutput("preRstAWait", {31'd0, a_waitrequest}, 32'd0);
        nextCycle();
        reset = 1'b1;
        idleMasters();
        @(negedge clk);
        checkOutput("rstAValid", {31'd0, a_readdatavalid}, 32'd0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 14'd7, 4'hF, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 14'd5, 4'hF, '0);
        @(negedge clk);
        checkOutput("postRstAValid", {31'd0, a_readdatavalid}, 32'd0);
        checkOutput("postRstAWait", {31'd0, a_waitrequest}, 32'd0);
        checkOutput("postRstBWait", {31'd0, b_waitrequest}, 32'd1);
        pushExpect(1'b0, 32'h00003344, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("postRstBGrant", {31'd0, b_waitrequest}, 32'd0);
        pushExpect(1'b1, 32'hDEADBEEF, 1'b0);
        nextCycle();
        idleMasters();
        repeat (3) nextCycle();

        @(negedge clk);
        checkOutput("sbEmpty", sbQueue.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
